// File: rtl/isp_gamma_stream.sv
// Gamma LUT stage on the RGB pixel stream.
// Double-buffered 256x8 table, committed on frame start.
module isp_gamma_stream #(
  parameter int BITS = 8
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            table_wen,
  input  logic [7:0]      table_addr,
  input  logic [7:0]      table_wdata,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_r,
  output logic [BITS-1:0] out_g,
  output logic [BITS-1:0] out_b,
  output logic            table_valid,
  output logic            swap_pending,
  output logic            active_bank
);

  localparam int PAD = BITS - 8;

  logic [7:0] bank0 [256];
  logic [7:0] bank1 [256];

  logic prev_vsync;
  logic fs;
  logic wr_last;

  logic            s1_href;
  logic            s1_vsync;
  logic            s1_byp;
  logic            s1_bank;
  logic [BITS-1:0] s1_r;
  logic [BITS-1:0] s1_g;
  logic [BITS-1:0] s1_b;

  logic [7:0] idx_r;
  logic [7:0] idx_g;
  logic [7:0] idx_b;
  logic [7:0] lut_r;
  logic [7:0] lut_g;
  logic [7:0] lut_b;

  assign fs      = in_vsync & ~prev_vsync;
  assign wr_last = table_wen & (table_addr == 8'hff);

  function automatic logic [BITS-1:0] ext(
    input logic [7:0] v
  );
    logic [BITS-1:0] t;
    t = BITS'(v);
    return t << PAD;
  endfunction

  // Loads always land in the bank not used for lookup
  always_ff @(posedge pclk) begin
    if (table_wen) begin
      if (active_bank)
        bank0[table_addr] <= table_wdata;
      else
        bank1[table_addr] <= table_wdata;
    end
  end

  // A last-entry write at the frame edge defers the swap
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vsync   <= 1'b0;
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      table_valid  <= 1'b0;
    end else begin
      prev_vsync <= in_vsync;
      if (fs && swap_pending && !wr_last) begin
        active_bank  <= ~active_bank;
        swap_pending <= 1'b0;
        table_valid  <= 1'b1;
      end else if (wr_last) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_href  <= 1'b0;
      s1_vsync <= 1'b0;
      s1_byp   <= 1'b1;
      s1_bank  <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
    end else begin
      s1_href  <= in_href;
      s1_vsync <= in_vsync;
      s1_byp   <= ~enable | ~table_valid;
      s1_bank  <= active_bank;
      s1_r     <= in_r;
      s1_g     <= in_g;
      s1_b     <= in_b;
    end
  end

  always_comb begin
    idx_r = s1_r[BITS-1-:8];
    idx_g = s1_g[BITS-1-:8];
    idx_b = s1_b[BITS-1-:8];
    lut_r = s1_bank ? bank1[idx_r] : bank0[idx_r];
    lut_g = s1_bank ? bank1[idx_g] : bank0[idx_g];
    lut_b = s1_bank ? bank1[idx_b] : bank0[idx_b];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      out_href  <= s1_href;
      out_vsync <= s1_vsync;
      if (!s1_href) begin
        out_r <= '0;
        out_g <= '0;
        out_b <= '0;
      end else if (s1_byp) begin
        out_r <= s1_r;
        out_g <= s1_g;
        out_b <= s1_b;
      end else begin
        out_r <= ext(lut_r);
        out_g <= ext(lut_g);
        out_b <= ext(lut_b);
      end
    end
  end

endmodule

// File: tb/tb_isp_gamma_stream.sv
// Scoreboard bench for isp_gamma_stream.
// Runs BITS=8 and BITS=10 instances side by side.
module tb_isp_gamma_stream;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       table_wen = 1'b0;
  logic [7:0] table_addr = '0;
  logic [7:0] table_wdata = '0;
  logic       in_href = 1'b0;
  logic       in_vsync = 1'b0;
  logic [7:0] in_r = '0;
  logic [7:0] in_g = '0;
  logic [7:0] in_b = '0;

  logic       oh8, ov8, tv8, sp8, ab8;
  logic [7:0] or8, og8, ob8;
  logic       oh10, ov10, tv10, sp10, ab10;
  logic [9:0] or10, og10, ob10;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [1:0] vh = '0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t q[$];

  always #5 pclk = ~pclk;

  isp_gamma_stream #(.BITS(8)) dut8 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .table_wen(table_wen), .table_addr(table_addr),
    .table_wdata(table_wdata),
    .in_href(in_href), .in_vsync(in_vsync),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_href(oh8), .out_vsync(ov8),
    .out_r(or8), .out_g(og8), .out_b(ob8),
    .table_valid(tv8), .swap_pending(sp8),
    .active_bank(ab8)
  );

  isp_gamma_stream #(.BITS(10)) dut10 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .table_wen(table_wen), .table_addr(table_addr),
    .table_wdata(table_wdata),
    .in_href(in_href), .in_vsync(in_vsync),
    .in_r({in_r, 2'b00}), .in_g({in_g, 2'b00}),
    .in_b({in_b, 2'b00}),
    .out_href(oh10), .out_vsync(ov10),
    .out_r(or10), .out_g(og10), .out_b(ob10),
    .table_valid(tv10), .swap_pending(sp10),
    .active_bank(ab10)
  );

  task automatic chk(
    input string       name,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gam(input int x);
    real v;
    v = 255.0 * $pow(real'(x) / 255.0, 1.0 / 2.2);
    return 8'($rtoi(v));
  endfunction

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (!rst_n) vh <= '0;
    else vh <= {vh[0], in_vsync};
  end

  // Monitor
  always @(negedge pclk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_out8", {oh8, ov8, or8, og8, ob8}, '0);
      chk("rst_out10", {oh10, ov10, or10, og10, ob10}, '0);
    end else begin
      chk("vsync_dly8", ov8, vh[1]);
      chk("vsync_dly10", ov10, vh[1]);
      chk("href_match", oh10, oh8);
      if (oh8) begin
        if (q.size() == 0) begin
          chk("unexpected_pix", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("pix8", {or8, og8, ob8}, {e.r, e.g, e.b});
          chk("pix10", {or10, og10, ob10},
              {e.r, 2'b00, e.g, 2'b00, e.b, 2'b00});
        end
      end else begin
        chk("idle_zero8", {or8, og8, ob8}, '0);
        chk("idle_zero10", {or10, og10, ob10}, '0);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      in_href   = 1'b0;
      in_vsync  = 1'b0;
      table_wen = 1'b0;
    end
  endtask

  task automatic pix(
    input logic       en,
    input logic [7:0] r, g, b,
    input logic [7:0] er, eg, eb
  );
    exp_t e;
    @(negedge pclk);
    enable    = en;
    in_href   = 1'b1;
    in_vsync  = 1'b0;
    table_wen = 1'b0;
    in_r = r;
    in_g = g;
    in_b = b;
    e.r = er;
    e.g = eg;
    e.b = eb;
    e.cyc = cyc + 2;
    q.push_back(e);
  endtask

  task automatic wr(
    input logic [7:0] a,
    input logic [7:0] d,
    input logic       vs
  );
    @(negedge pclk);
    in_href     = 1'b0;
    in_vsync    = vs;
    table_wen   = 1'b1;
    table_addr  = a;
    table_wdata = d;
  endtask

  task automatic load(input bit gamma, input bit vs_last);
    for (int a = 0; a < 256; a++)
      wr(8'(a), gamma ? gam(a) : 8'(a),
         vs_last && (a == 255));
  endtask

  task automatic vs();
    @(negedge pclk);
    in_href   = 1'b0;
    in_vsync  = 1'b1;
    table_wen = 1'b0;
    idle(1);
  endtask

  task automatic status(
    input string name,
    input logic  v, p, a
  );
    chk({name, "_valid"}, {tv8, tv10}, {v, v});
    chk({name, "_pend"}, {sp8, sp10}, {p, p});
    chk({name, "_bank"}, {ab8, ab10}, {a, a});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures + 1);
    $fatal(1);
  end

  initial begin
    idle(3);
    status("reset", 0, 0, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    idle(2);

    // bypass before any table
    pix(1, 77, 128, 200, 77, 128, 200);
    idle(3);
    status("bypass", 0, 0, 0);

    // gamma commit
    load(1, 0);
    idle(1);
    status("precommit", 0, 1, 0);
    vs();
    status("commit", 1, 0, 1);
    pix(1, 1, 128, 255, 20, 186, 255);
    idle(3);

    // identity active, gamma loaded mid-frame
    load(0, 0);
    vs();
    status("ident", 1, 0, 0);
    pix(1, 1, 1, 1, 1, 1, 1);
    load(1, 0);
    pix(1, 1, 128, 255, 1, 128, 255);
    idle(2);
    vs();
    pix(1, 1, 1, 1, 20, 20, 20);
    idle(3);

    // last write coincides with frame start
    for (int a = 0; a < 255; a++)
      wr(8'(a), 8'(a), 0);
    wr(8'hff, 8'hff, 1);
    idle(1);
    status("simul", 1, 1, 1);
    pix(1, 1, 128, 1, 20, 186, 20);
    idle(3);
    vs();
    status("simul_swap", 1, 0, 0);
    pix(1, 1, 128, 1, 1, 128, 1);
    idle(3);

    // enable toggled mid-line
    load(1, 0);
    vs();
    pix(1, 128, 128, 128, 186, 186, 186);
    pix(0, 128, 1, 255, 128, 1, 255);
    pix(1, 128, 1, 255, 186, 20, 255);
    idle(3);

    // reset mid-frame
    pix(1, 128, 128, 128, 186, 186, 186);
    idle(3);
    @(negedge pclk);
    in_href = 1'b1;
    in_r = 8'd128;
    @(posedge pclk);
    #2 rst_n = 1'b0;
    @(negedge pclk);
    in_href = 1'b0;
    status("midrst", 0, 0, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    idle(2);
    pix(1, 128, 128, 128, 128, 128, 128);
    idle(3);
    status("postrst", 0, 0, 0);
    load(1, 0);
    pix(1, 128, 1, 255, 128, 1, 255);
    idle(2);
    vs();
    status("recommit", 1, 0, 1);
    pix(1, 128, 1, 255, 186, 20, 255);
    idle(4);

    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
